// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// One bit per cycle; start/busy/done handshake and a divide-by-zero flag.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t                 r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_opnd;
  logic                   r_is_div;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_done;
  logic                   r_dbz;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  logic                   w_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic                   w_accept;
  logic                   w_dbz;
  logic [WIDTH:0]         w_mul_sum;
  logic [WIDTH:0]         w_div_diff;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_dbz    = w_accept && op[1] && (b == '0);

  // Multiply: low half holds the unconsumed multiplier bits, high half the
  // running partial product; the carry drops into bit 2W-1 on the shift.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Divide: trial-subtract the divisor from the remainder shifted left by one.
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

  always_comb begin
    w_acc_next = r_acc;
    if (r_is_div) begin
      if (!w_div_diff[WIDTH])
        w_acc_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_dbz) w_next_state = S_RUN;
      S_RUN:  if (r_cnt == CNT_W'(1)) w_next_state = S_FIX;
      S_FIX:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dbz <= w_dbz;
            if (w_dbz) begin
              r_done <= 1'b1;
            end else begin
              r_is_div <= op[1];
              r_cnt    <= CNT_W'(WIDTH);
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
              r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8,
// checked against an integer-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we, sel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;

  logic        start32, hi_we32, lo_we32, busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        start8, hi_we8, lo_we8, busy8, done8, dbz8;
  logic [7:0]  hi8, lo8, a8, b8, wdata8;

  logic        o_busy, o_done, o_dbz;
  logic [63:0] o_hi, o_lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_hi[2];
  logic [63:0] m_lo[2];
  bit          m_dbz[2];

  always #5 clk = ~clk;

  assign start32 = start & ~sel;
  assign hi_we32 = hi_we & ~sel;
  assign lo_we32 = lo_we & ~sel;
  assign start8  = start & sel;
  assign hi_we8  = hi_we & sel;
  assign lo_we8  = lo_we & sel;
  assign a8      = a[7:0];
  assign b8      = b[7:0];
  assign wdata8  = wdata[7:0];

  assign o_busy = sel ? busy8 : busy32;
  assign o_done = sel ? done8 : done32;
  assign o_dbz  = sel ? dbz8  : dbz32;
  assign o_hi   = sel ? {56'd0, hi8} : {32'd0, hi32};
  assign o_lo   = sel ? {56'd0, lo8} : {32'd0, lo32};

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_w();
    return sel ? 8 : 32;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model(input int w, input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] eh, output logic [63:0] el, output bit edbz);
    logic [63:0]     msk;
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     p, q, r;
    msk  = mask_of(w);
    ua   = av & msk;
    ub   = bv & msk;
    sa   = sx(ua, w);
    sb   = sx(ub, w);
    edbz = 1'b0;
    eh   = 64'd0;
    el   = 64'd0;
    case (o)
      2'd0: begin sp = sa * sb; p = sp; eh = (p >> w) & msk; el = p & msk; end
      2'd1: begin up = ua * ub; p = up; eh = (p >> w) & msk; el = p & msk; end
      2'd2: if (sb == 0) edbz = 1'b1;
            else begin q = sa / sb; r = sa % sb; el = q & msk; eh = r & msk; end
      default: if (ub == 0) edbz = 1'b1;
            else begin q = ua / ub; r = ua % ub; el = q & msk; eh = r & msk; end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv, input bit disturb);
    int w, k, nb;
    logic [63:0] eh, el;
    bit edbz;
    w = cur_w();
    model(w, o, av, bv, eh, el, edbz);
    op = o; a = av[31:0]; b = bv[31:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (edbz) begin
      check("dbz_busy", {63'd0, o_busy}, 64'd0);
      check("dbz_done", {63'd0, o_done}, 64'd1);
      check("dbz_flag", {63'd0, o_dbz}, 64'd1);
      check("dbz_hi", o_hi, m_hi[sel]);
      check("dbz_lo", o_lo, m_lo[sel]);
      @(posedge clk); #1;
      check("dbz_done_pulse", {63'd0, o_done}, 64'd0);
      check("dbz_flag_held", {63'd0, o_dbz}, 64'd1);
      m_dbz[sel] = 1'b1;
      return;
    end
    k = 0; nb = 0;
    while (!o_done && k < w + 6) begin
      if (o_busy) nb++;
      if (k == 2) begin
        check("hold_hi", o_hi, m_hi[sel]);
        check("hold_lo", o_lo, m_lo[sel]);
      end
      if (disturb && k == 5) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      if (disturb && k == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("latency", k, w + 1);
    check("busy_cycles", nb, w + 1);
    check("done", {63'd0, o_done}, 64'd1);
    check("busy_at_done", {63'd0, o_busy}, 64'd0);
    check("dbz_clear", {63'd0, o_dbz}, 64'd0);
    check($sformatf("hi op%0d", o), o_hi, eh);
    check($sformatf("lo op%0d", o), o_lo, el);
    m_hi[sel] = eh; m_lo[sel] = el; m_dbz[sel] = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", {63'd0, o_done}, 64'd0);
  endtask

  task automatic wr(input bit hw, input bit lw, input logic [63:0] d);
    wdata = d[31:0]; hi_we = hw; lo_we = lw;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi[sel] = d & mask_of(cur_w());
    if (lw) m_lo[sel] = d & mask_of(cur_w());
    check("wr_hi", o_hi, m_hi[sel]);
    check("wr_lo", o_lo, m_lo[sel]);
  endtask

  task automatic reset_mid(input int cyc);
    int nd;
    op = 2'd1; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (cyc - 1) begin @(posedge clk); #1; end
    check("pre_rst_busy", {63'd0, o_busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_dbz", {63'd0, o_dbz}, 64'd0);
    check("rst_hi", o_hi, 64'd0);
    check("rst_lo", o_lo, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; m_dbz[i] = 1'b0; end
    nd = 0;
    repeat (cur_w() + 4) begin
      @(posedge clk); #1;
      if (o_done) nd++;
    end
    check("rst_no_done", nd, 0);
  endtask

  function automatic logic [63:0] pick(input int w);
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return mask_of(w);
      2: return 64'd1 << (w - 1);
      3: return 64'd1;
      default: return {32'd0, $urandom} & mask_of(w);
    endcase
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; sel = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; m_dbz[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_busy", {63'd0, o_busy}, 64'd0);
      check("reset_done", {63'd0, o_done}, 64'd0);
      check("reset_dbz", {63'd0, o_dbz}, 64'd0);
      check("reset_hi", o_hi, 64'd0);
      check("reset_lo", o_lo, 64'd0);
    end
    sel = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 64'hFFFFFFFD, 64'd7, 1'b0);
    run_op(2'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0);
    run_op(2'd2, 64'hFFFFFFF9, 64'd2, 1'b0);
    run_op(2'd3, 64'd100, 64'd7, 1'b0);
    run_op(2'd2, 64'h80000000, 64'hFFFFFFFF, 1'b0);
    run_op(2'd1, 64'h01234567, 64'h89ABCDEF, 1'b1);
    run_op(2'd2, 64'h87654321, 64'h00001234, 1'b1);
    wr(1'b1, 1'b1, 64'h12345678);
    run_op(2'd2, 64'd5, 64'd0, 1'b0);
    run_op(2'd3, 64'd9, 64'd0, 1'b0);
    run_op(2'd1, 64'd3, 64'd4, 1'b0);
    wr(1'b1, 1'b0, 64'hCAFEF00D);
    wr(1'b0, 1'b1, 64'h0BADBEEF);
    reset_mid(10);
    run_op(2'd1, 64'd3, 64'd4, 1'b0);
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(32), pick(32), ($urandom_range(0, 3) == 0));

    sel = 1'b1;
    @(posedge clk); #1;
    run_op(2'd0, 64'h80, 64'h80, 1'b0);
    run_op(2'd2, 64'h80, 64'hFF, 1'b0);
    reset_mid(5);
    run_op(2'd0, 64'h80, 64'h80, 1'b0);
    wr(1'b1, 1'b1, 64'hA5);
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(8), pick(8), ($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with integrated HI/LO result registers, replacing the separate fixed 32-bit multiplier, divider, HI/LO select muxes and HI/LO registers in the multicycle CPU datapath. It performs signed and unsigned multiply and divide of WIDTH-bit operands one bit per cycle. It hands off to the control FSM through a start/busy/done handshake and flags division by zero for the exception path. It also gives the control FSM direct HI/LO write ports for MTHI/MTLO.

## Interface
- WIDTH, 32, operand and HI/LO width; any value ≥ 4
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- hi_we  in  1  write wdata into HI (MTHI)
- lo_we  in  1  write wdata into LO (MTLO)
- wdata  in  WIDTH  direct write data
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when an operation completes, including aborted divide-by-zero
- div_by_zero  out  1  level; set by DIV/DIVU with b==0 and held until the next accepted start
- hi  out  WIDTH  HI register: product upper half, or remainder
- lo  out  WIDTH  LO register: product lower half, or quotient

## Operation
- FSM states are IDLE, RUN and FIX. busy = (state != IDLE).
- **Accept:** start is accepted when in IDLE with start=1. Edge E0 captures op and the operand magnitudes. For signed ops, negative operands are two's-complement negated. The result signs are latched: for a product, sign(a) XOR sign(b); for a quotient, the same; for a remainder, sign(a). At E0 the counter is loaded with WIDTH, div_by_zero is cleared, and the FSM goes to RUN.
- **Divide by zero:** a DIV or DIVU accept with b==0 sets div_by_zero=1 at E0 and stays in IDLE. done pulses in the following cycle. HI and LO are unchanged.
- **RUN, multiply:** radix-2 shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per edge.
- **RUN, divide:** restoring division, one quotient bit per edge.
- **RUN counter:** decrements once per edge; the FSM moves RUN→FIX on the edge where the counter reaches 0. RUN therefore lasts exactly WIDTH edges.
- **FIX:** applies the sign correction and writes HI/LO on the FIX edge, drives done=1 for the next cycle, and returns to IDLE.
- **Signed division:** the quotient truncates toward zero and the remainder takes the sign of the dividend.
- **Most-negative ÷ −1 (signed):** lo = most-negative value (wrap), hi = 0. No flag is raised.
- **Products:** full 2·WIDTH bits; no overflow is possible.
- **Direct writes:** hi_we / lo_we update HI / LO only in IDLE and only when start is not accepted on the same edge. Otherwise the write is ignored. hi_we and lo_we may be asserted together.
- start, hi_we and lo_we are ignored while busy.
- **Reset:** asynchronous, at any time, including mid-operation. The operation is abandoned; no done pulse is generated for it.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0. The counter and accumulators are cleared.
- Accept at edge E0 → busy high from E0 until edge E0+WIDTH+1.
- HI/LO are updated at E0+WIDTH+1. done is high for exactly the one cycle following that edge, with busy=0 in that cycle.
- Total latency is WIDTH+1 cycles from accept to result visible (33 cycles for WIDTH=32).
- A new start may be accepted in the same cycle that done is high; back-to-back throughput is one operation per WIDTH+2 cycles.
- Divide-by-zero: done and div_by_zero are both high in the cycle after E0; busy never rises.
- hi and lo are registered outputs and are stable throughout RUN and FIX, holding their previous values.

## Test plan
- **MULT:** WIDTH=32, a=0xFFFFFFFD (−3), b=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done is a single-cycle pulse; busy is high for 33 cycles.
- **MULTU:** a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **DIV and DIVU:**
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** hi=lo=0x12345678 preloaded via hi_we/lo_we, then DIV a=5, b=0 → next cycle done=1, div_by_zero=1, busy stays 0, hi/lo unchanged. A subsequent MULTU 3×4 clears the flag and gives lo=12, hi=0.
- **Ignored inputs while busy:** start, hi_we and lo_we pulsed during RUN have no effect; the result of the original operation is intact.
- **Reset:** rst low for 1 cycle at cycle 10 of a MULTU → all outputs 0 immediately (asynchronous), no done pulse; a new start afterwards completes normally. Repeat with WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00, with 9-cycle latency.
